fetch_unit: RTL

//   Instruction fetch stage of the 16-bit core. Owns the program counter and drives

---
 rtl/fetch_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory,
// and hands each non-zero word to decode through a one-entry fetch register.
module fetch_unit #(
    parameter int            L        = 16,
    parameter logic [L-1:0]  RESET_PC = '0
) (
    input  logic         Clock,
    input  logic         ResetN,
    output logic [L-1:0] Address,
    input  logic [L-1:0] Instruction,
    input  logic         DecodeReady,
    input  logic         Redirect,
    input  logic [L-1:0] RedirectTarget,
    output logic         FetchValid,
    output logic [L-1:0] FetchInstr,
    output logic [L-1:0] FetchPC,
    output logic         Halted,
    output logic [L-1:0] FetchCount,
    output logic [1:0]   DebugState
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e       state_q;
    logic [L-1:0] pc_q;
    logic         valid_q;
    logic [L-1:0] instr_q;
    logic [L-1:0] fpc_q;
    logic         halted_q;
    logic [L-1:0] count_q;

    // Decode handshake: a word transfers on any edge where FetchValid and
    // DecodeReady are both high; FetchValid never drops without that transfer
    // except on Redirect or reset, and the register may refill in the same cycle.
    logic advance;
    logic handshake;

    assign advance   = !valid_q || DecodeReady;
    assign handshake = valid_q && DecodeReady;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            fpc_q    <= '0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            // A handshake on a redirect cycle still counts; the flush follows it.
            if (handshake) begin
                count_q <= count_q + L'(1);
            end

            if (Redirect) begin
                pc_q     <= RedirectTarget;
                valid_q  <= 1'b0;
                halted_q <= 1'b0;
                state_q  <= ST_RUN;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (advance) begin
                            if (Instruction != '0) begin
                                instr_q <= Instruction;
                                fpc_q   <= pc_q;
                                valid_q <= 1'b1;
                                pc_q    <= pc_q + L'(1);
                            end else begin
                                // Zero word marks unmapped memory; never shown to decode.
                                valid_q  <= 1'b0;
                                halted_q <= 1'b1;
                                state_q  <= ST_HALTED;
                            end
                        end
                    end
                    ST_HALTED: begin
                        if (DecodeReady) begin
                            valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Address    = pc_q;
    assign FetchValid = valid_q;
    assign FetchInstr = instr_q;
    assign FetchPC    = fpc_q;
    assign Halted     = halted_q;
    assign FetchCount = count_q;
    assign DebugState = state_q;

endmodule
